ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
- PS/2 device-to-host receiver.
- Oversamples the keyboard's ps2_clk/ps2_data lines on the system clock, deframes 11-bit frames and validates them.
- Pushes each valid scan-code byte into a small FIFO.
- Sits between the keyboard pins and a scan-code consumer (press/release decoder), which pops bytes with a nextdata_n strobe.

Parameters:
- FIFO_DEPTH, 8: number of byte entries in the receive FIFO; power of two, at least 2.
- TIMEOUT_CYCLES, 50000: clk cycles with no ps2_clk falling edge, mid-frame, before the partial frame is abandoned.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clrn  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
- nextdata_n  input  1  active-low pop request, sampled every clk.
- data  output  8  byte at FIFO head; registered storage, combinational head select.
- ready  output  1  FIFO non-empty.
- overflow  output  1  a valid byte was dropped because the FIFO was full.

Behaviour:
- Reset (clrn=0, asynchronous):
  - Clears synchronizer, bit counter, shift register, timeout counter, FIFO pointers, occupancy and all FIFO storage.
  - Outputs after reset: data=8'h00, ready=0, overflow=0.
  - Reset asserted mid-frame discards the partial frame.
- Synchronizer and edge detect:
  - ps2_clk passes through a 3-flop shift register; ps2_data through 2 flops.
  - A falling edge is detected when the two oldest ps2_clk samples are 1 then 0.
  - ps2_data is sampled on that clk cycle.
- Frame format:
  - Bit 0 start (must be 0); bits 1-8 D0..D7, LSB first; bit 9 odd parity; bit 10 stop (must be 1).
  - A 4-bit counter counts 0..10, one step per falling edge.
- Frame check, on the edge that captures bit 10:
  - Valid if start=0, stop=1 and XOR of D0..D7 and parity = 1.
  - Counter returns to 0 regardless of validity.
  - An invalid frame is silently discarded; no flag is raised.
- Push: a valid byte is written at the write pointer on the cycle after the bit-10 edge, and occupancy increments.
- Latency: ready rises at most 2 clk cycles after the synchronized bit-10 falling edge.
- Full FIFO: a push with occupancy=FIFO_DEPTH and no simultaneous pop drops the new byte and sets overflow=1. Existing contents are untouched.
- Pop:
  - Any clk cycle with nextdata_n=0 and ready=1 advances the read pointer and decrements occupancy.
  - Holding nextdata_n low pops one byte per cycle.
  - nextdata_n=0 while empty is ignored.
- Simultaneous push and pop: both take effect and occupancy is unchanged. When full, the push is accepted and no overflow is raised.
- overflow is sticky until the next successful pop or reset.
- ready = (occupancy != 0). data = storage[read pointer] at all times; when empty it shows the stale entry at the read pointer.
- Pointers wrap modulo FIFO_DEPTH.
- Timeout:
  - While the bit counter is nonzero, a cycle counter increments each clk and clears on every falling edge.
  - On reaching TIMEOUT_CYCLES, the bit counter and shift register clear; no byte is pushed.
  - The counter is idle while the bit counter is 0.
- ps2_data is don't-care outside falling edges; glitches on ps2_clk shorter than one clk are not filtered.

Test Plan:
- Reset, then send frame for 8'h1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> within 2 clk of last edge ready=1, data=8'h1C, overflow=0. Pulse nextdata_n low 1 cycle -> ready=0.
- Send 8'hF0 then 8'h1C without popping -> data=8'hF0; one pop -> data=8'h1C, ready=1; second pop -> ready=0.
- Send 8'h1C with parity bit 1 (bad), then one with stop=0 -> ready stays 0, overflow stays 0.
- Send FIFO_DEPTH+1 valid frames (8'h01..8'h09), no pops -> overflow=1 after the 9th. Popping 8 times yields 8'h01..8'h08; overflow clears on the first pop.
- Send 5 bits of a frame, idle TIMEOUT_CYCLES+10 clk, then a full valid 8'h32 frame -> exactly one byte, 8'h32, received.
- Assert clrn=0 mid-frame with 2 bytes queued -> ready=0, data=8'h00, overflow=0 immediately. Next full frame 8'h1C is received correctly.

Source files
------------

// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
// PS/2 device-to-host receiver: oversampled deframing of 11-bit frames into a byte FIFO.
// Latency: byte is visible (ready=1) 2 clk after the synchronized falling edge of the stop bit.
// Backpressure: none toward the keyboard; a byte arriving while the FIFO is full is dropped and flagged on overflow.
//
// Ports:
//   clk        system clock, all logic on posedge
//   clrn       asynchronous active-low reset
//   ps2_clk    raw PS/2 clock line (asynchronous)
//   ps2_data   raw PS/2 data line (asynchronous)
//   nextdata_n active-low pop strobe, one byte per cycle while low and non-empty
//   data       byte at FIFO head (stale entry when empty)
//   ready      FIFO non-empty
//   overflow   sticky: a valid byte was dropped; clears on the next pop
module ps2_keyboard #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizers and falling-edge detect
    // ------------------------------------------------------------------
    logic [2:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       ps2_fall;
    logic       ps2_bit;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // Two oldest clock samples 1 then 0; the first two flops only resolve metastability.
    assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign ps2_bit  = dat_sync_q[1];

    // ------------------------------------------------------------------
    // Deframer: bit counter, shift register, inactivity timeout
    // ------------------------------------------------------------------
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    shift_q, shift_d;      // frame bits 0..9; bit 10 is taken live
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_vld_q, push_vld_d;
    logic [7:0]    push_dat_q, push_dat_d;
    logic          frame_ok;

    // Start low, stop high, odd parity across D0..D7 plus the parity bit.
    assign frame_ok = ~shift_q[0] & ps2_bit & (^shift_q[9:1]);

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        push_vld_d = 1'b0;
        push_dat_d = push_dat_q;

        if (ps2_fall) begin
            tmo_d = '0;
            if (cnt_q == 4'd10) begin
                cnt_d      = 4'd0;
                push_vld_d = frame_ok;
                push_dat_d = shift_q[8:1];
            end else begin
                shift_d[cnt_q] = ps2_bit;
                cnt_d          = cnt_q + 4'd1;
            end
        end else if (cnt_q != 4'd0) begin
            // Keyboard stalled mid-frame: abandon the partial frame so the
            // next start bit lines up with bit 0 again.
            if (tmo_q == TMO_LAST) begin
                cnt_d   = 4'd0;
                shift_d = '0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            push_vld_q <= push_vld_d;
            push_dat_q <= push_dat_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          full;
    logic          wr_en;

    assign pop   = ~nextdata_n & (occ_q != '0);
    assign full  = (occ_q == OCC_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push_vld_q & (~full | pop);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        occ_d = occ_q;
        ovf_d = ovf_q;

        if (wr_en) wp_d = wp_q + AW'(1);
        if (pop)   rp_d = rp_q + AW'(1);

        if (wr_en && !pop)      occ_d = occ_q + OW'(1);
        else if (!wr_en && pop) occ_d = occ_q - OW'(1);

        if (pop)                   ovf_d = 1'b0;
        else if (push_vld_q && full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wp_q] <= push_dat_q;
        end
    end

    assign data     = mem_q[rp_q];
    assign ready    = (occ_q != '0);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int H     = 8;   // PS/2 half-period in clk cycles

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of bytes the consumer should see, plus sticky flag.
    byte unsigned exp_q[$];
    bit           exp_ovf = 1'b0;

    ps2_keyboard #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ((ones % 2) == 0) ^ bad_par;   // make total ones odd
        f[10]  = ~bad_stop;
        return f;
    endfunction

    function automatic bit frame_valid(input logic [10:0] f);
        int ones;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += f[i];
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ((ones % 2) == 1);
    endfunction

    task automatic model_frame(input logic [10:0] f);
        if (frame_valid(f)) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(f[8:1]);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive_bit(f[i]);
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_bits(f, 0, 10);
        repeat (4) @(negedge clk);
        model_frame(f);
    endtask

    // Hold nextdata_n low for n cycles; each cycle pops one byte if any.
    task automatic pop_n(input int n);
        if (n > 0) begin
            @(negedge clk) nextdata_n = 1'b0;
            repeat (n) @(negedge clk);
            nextdata_n = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    exp_ovf = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        clrn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [10:0] f;
        int          k;
        f = mk_frame(8'h1C, 0, 0);
        send_bits(f, 0, 9);
        @(negedge clk) ps2_data = f[10];
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        // 2 flops of sync plus 2 clk of push latency after the raw edge
        k = 0;
        while (k < 4 && ready !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_latency: ready=%b after %0d clk, want 1 within 4", ready, k); end
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        model_frame(f);
        checks++; if (data !== 8'h1C) begin errors++; $display("FAIL basic_data: got %h want 1c", data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", overflow); end
        pop_n(1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_pop_ready: got %b want 0", ready); end
    endtask

    task automatic test_two;
        send_frame(mk_frame(8'hF0, 0, 0));
        send_frame(mk_frame(8'h1C, 0, 0));
        checks++; if (data !== 8'hF0) begin errors++; $display("FAIL two_head: got %h want f0", data); end
        pop_n(1);
        checks++; if (data !== 8'h1C) begin errors++; $display("FAIL two_second: got %h want 1c", data); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL two_ready: got %b want 1", ready); end
        pop_n(1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL two_empty: got %b want 0", ready); end
        // Pop while empty must not disturb anything
        pop_n(2);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL empty_pop_ready: got %b want 0", ready); end
    endtask

    task automatic test_bad;
        send_frame(mk_frame(8'h1C, 1, 0));
        send_frame(mk_frame(8'h1C, 0, 1));
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bad_ready: got %b want 0", ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bad_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(mk_frame(8'(i), 0, 0));
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b want 1", ready); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (data !== 8'(i)) begin errors++; $display("FAIL ovf_drain_%0d: got %h want %h", i, data, 8'(i)); end
            pop_n(1);
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_%0d: got %b want 0", i, overflow); end
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", ready); end
    endtask

    task automatic test_timeout;
        send_bits(mk_frame(8'hAA, 0, 0), 0, 4);
        repeat (TMO + 10) @(negedge clk);
        send_frame(mk_frame(8'h32, 0, 0));
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL tmo_ready: got %b want 1", ready); end
        checks++; if (data !== 8'h32) begin errors++; $display("FAIL tmo_data: got %h want 32", data); end
        pop_n(1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL tmo_single: got %b want 0", ready); end
    endtask

    // A stall shorter than the timeout must keep the partial frame.
    task automatic test_resume;
        logic [10:0] f;
        f = mk_frame(8'h5A, 0, 0);
        send_bits(f, 0, 4);
        repeat (TMO / 3) @(negedge clk);
        send_bits(f, 5, 10);
        repeat (4) @(negedge clk);
        model_frame(f);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL resume_ready: got %b want 1", ready); end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL resume_data: got %h want 5a", data); end
        pop_n(1);
    endtask

    task automatic test_random;
        logic [7:0]  b;
        logic [10:0] f;
        bit          bp, bs;
        for (int it = 0; it < 40; it++) begin
            b  = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 7) == 0);
            f  = mk_frame(b, bp, bs);
            send_frame(f);
            checks++; if (ready !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_ready_%0d: got %b want %b", it, ready, exp_q.size() != 0); end
            checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_ovf_%0d: got %b want %b", it, overflow, exp_ovf); end
            if (exp_q.size() != 0) begin
                checks++; if (data !== exp_q[0]) begin errors++; $display("FAIL rand_data_%0d: got %h want %h", it, data, exp_q[0]); end
            end
            pop_n(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            checks++; if (ready !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_pop_ready_%0d: got %b want %b", it, ready, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if (data !== exp_q[0]) begin errors++; $display("FAIL rand_pop_data_%0d: got %h want %h", it, data, exp_q[0]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        pop_n(DEPTH + 1);
        send_frame(mk_frame(8'h11, 0, 0));
        send_frame(mk_frame(8'h22, 0, 0));
        send_bits(mk_frame(8'h77, 0, 0), 0, 3);
        @(negedge clk) clrn = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", ready); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(mk_frame(8'h1C, 0, 0));
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_rx_ready: got %b want 1", ready); end
        checks++; if (data !== 8'h1C) begin errors++; $display("FAIL rstmid_rx_data: got %h want 1c", data); end
        pop_n(1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_single: got %b want 0", ready); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_two;
        test_bad;
        test_overflow;
        test_timeout;
        test_resume;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
